// File: rtl/huffman_tree.sv
// huffman_tree: builds a 10-leaf Huffman tree with one merge per cycle.
// Every cycle the two lightest active entries of a 19-entry table are merged
// into the next internal node, and the merged pair is recorded.
// Optional build macro HT_ZERO_SKIP_EN: zero-count leaves are excluded, and
// merging stops when a single active entry remains.
module huffman_tree (
    input  logic        Clk_in,
    input  logic        n_Rst,
    input  logic        Start_tree,
    input  logic [8:0]  Num0,
    input  logic [8:0]  Num1,
    input  logic [8:0]  Num2,
    input  logic [8:0]  Num3,
    input  logic [8:0]  Num4,
    input  logic [8:0]  Num5,
    input  logic [8:0]  Num6,
    input  logic [8:0]  Num7,
    input  logic [8:0]  Num8,
    input  logic [8:0]  Num9,
    output logic [14:0] Node0,
    output logic [14:0] Node1,
    output logic [14:0] Node2,
    output logic [14:0] Node3,
    output logic [14:0] Node4,
    output logic [14:0] Node5,
    output logic [14:0] Node6,
    output logic [14:0] Node7,
    output logic [4:0]  m1,
    output logic [4:0]  m2,
    output logic        Fin
);

    localparam int NLEAF = 10;
    localparam int NENT  = 19;

    typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

    state_t      state_q, state_d;
    logic [12:0] wt_q [NENT];
    logic [NENT-1:0] act_q;
    logic [3:0]  k_q;
    logic [14:0] node_q [8];
    logic [4:0]  m1_q, m2_q;
    logic        fin_q;

    logic [8:0]  num [NLEAF];
    assign num[0] = Num0;
    assign num[1] = Num1;
    assign num[2] = Num2;
    assign num[3] = Num3;
    assign num[4] = Num4;
    assign num[5] = Num5;
    assign num[6] = Num6;
    assign num[7] = Num7;
    assign num[8] = Num8;
    assign num[9] = Num9;

    // Two-pass minimum search; strict '<' makes the lower ID win on ties.
    logic        min1_ok, min2_ok;
    logic [4:0]  min1, min2;
    logic [12:0] w1, w2;
    always_comb begin
        min1_ok = 1'b0;
        min1    = '0;
        w1      = '0;
        min2_ok = 1'b0;
        min2    = '0;
        w2      = '0;
        for (int i = 0; i < NENT; i++) begin
            if (act_q[i] && (!min1_ok || wt_q[i] < w1)) begin
                min1_ok = 1'b1;
                min1    = 5'(i);
                w1      = wt_q[i];
            end
        end
        for (int i = 0; i < NENT; i++) begin
            if (act_q[i] && (5'(i) != min1) && (!min2_ok || wt_q[i] < w2)) begin
                min2_ok = 1'b1;
                min2    = 5'(i);
                w2      = wt_q[i];
            end
        end
    end

    logic [4:0] new_id;
    logic       no_pair;
    logic       merge_last;
    assign new_id  = 5'd10 + {1'b0, k_q};
    // With all leaves active there are always >= 2 entries in MERGE.
    assign no_pair = !min2_ok;

`ifdef HT_ZERO_SKIP_EN
    // Population count of the active table: the merge leaving one entry ends the build.
    logic [4:0] act_cnt;
    always_comb begin
        act_cnt = '0;
        for (int i = 0; i < NENT; i++) act_cnt = act_cnt + {4'd0, act_q[i]};
    end
    assign merge_last = (act_cnt == 5'd2);
`else
    assign merge_last = (k_q == 4'd8);
`endif

    // State register.
    always_ff @(posedge Clk_in or posedge n_Rst) begin
        if (n_Rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: one build per start request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start_tree)            state_d = MERGE;
            MERGE:   if (no_pair || merge_last) state_d = DONE;
            DONE:    if (!Start_tree)           state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Table load on start, one merge per MERGE cycle, outputs held otherwise.
    always_ff @(posedge Clk_in or posedge n_Rst) begin
        if (n_Rst) begin
            for (int i = 0; i < NENT; i++) wt_q[i] <= '0;
            for (int i = 0; i < 8; i++)    node_q[i] <= '0;
            act_q <= '0;
            k_q   <= '0;
            m1_q  <= '0;
            m2_q  <= '0;
            fin_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start_tree) begin
                        for (int i = 0; i < NENT; i++) begin
                            if (i < NLEAF) begin
                                wt_q[i] <= {4'd0, num[i]};
`ifdef HT_ZERO_SKIP_EN
                                act_q[i] <= (num[i] != 9'd0);
`else
                                act_q[i] <= 1'b1;
`endif
                            end else begin
                                wt_q[i]  <= '0;
                                act_q[i] <= 1'b0;
                            end
                        end
                        for (int i = 0; i < 8; i++) node_q[i] <= '0;
                        k_q   <= '0;
                        m1_q  <= '0;
                        m2_q  <= '0;
                        fin_q <= 1'b0;
                    end
                end
                MERGE: begin
                    if (no_pair) begin
                        // Degenerate tree: report the lone leaf (or 0) on both outputs.
                        m1_q  <= min1;
                        m2_q  <= min1;
                        fin_q <= 1'b1;
                    end else begin
                        act_q[min1]   <= 1'b0;
                        act_q[min2]   <= 1'b0;
                        act_q[new_id] <= 1'b1;
                        wt_q[new_id]  <= w1 + w2;
                        m1_q <= min1;
                        m2_q <= min2;
                        if (!k_q[3]) node_q[k_q[2:0]] <= {min1, min2, new_id};
                        k_q <= k_q + 4'd1;
                        if (merge_last) fin_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Node0 = node_q[0];
    assign Node1 = node_q[1];
    assign Node2 = node_q[2];
    assign Node3 = node_q[3];
    assign Node4 = node_q[4];
    assign Node5 = node_q[5];
    assign Node6 = node_q[6];
    assign Node7 = node_q[7];
    assign m1    = m1_q;
    assign m2    = m2_q;
    assign Fin   = fin_q;

endmodule

// File: tb/tb_huffman_tree.sv
// Directed bench for huffman_tree: hand-computed merge lists for a skewed
// histogram, a single-nonzero histogram, a mid-build reset, held start and ties.
module tb_huffman_tree;

    logic        Clk_in = 1'b0;
    logic        n_Rst;
    logic        Start_tree;
    logic [8:0]  num [10];
    logic [14:0] node [8];
    logic [4:0]  m1, m2;
    logic        Fin;

    int checks = 0;
    int errors = 0;

    always #5 Clk_in = ~Clk_in;

    huffman_tree dut (
        .Clk_in(Clk_in), .n_Rst(n_Rst), .Start_tree(Start_tree),
        .Num0(num[0]), .Num1(num[1]), .Num2(num[2]), .Num3(num[3]), .Num4(num[4]),
        .Num5(num[5]), .Num6(num[6]), .Num7(num[7]), .Num8(num[8]), .Num9(num[9]),
        .Node0(node[0]), .Node1(node[1]), .Node2(node[2]), .Node3(node[3]),
        .Node4(node[4]), .Node5(node[5]), .Node6(node[6]), .Node7(node[7]),
        .m1(m1), .m2(m2), .Fin(Fin)
    );

    function automatic logic [14:0] nd(input int a, input int b, input int c);
        logic [4:0] x, y, z;
        x = a[4:0];
        y = b[4:0];
        z = c[4:0];
        return {x, y, z};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge Clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [14:0] exp1 [8];
    logic [8:0]  cnt1 [10];

    initial begin
        exp1[0] = nd(8, 6, 10);  exp1[1] = nd(10, 7, 11);
        exp1[2] = nd(3, 5, 12);  exp1[3] = nd(11, 2, 13);
        exp1[4] = nd(12, 4, 14); exp1[5] = nd(9, 1, 15);
        exp1[6] = nd(13, 0, 16); exp1[7] = nd(14, 15, 17);
        cnt1[0] = 53; cnt1[1] = 40; cnt1[2] = 26; cnt1[3] = 14; cnt1[4] = 38;
        cnt1[5] = 23; cnt1[6] = 7;  cnt1[7] = 12; cnt1[8] = 4;  cnt1[9] = 39;

        n_Rst = 1'b1;
        Start_tree = 1'b0;
        for (int i = 0; i < 10; i++) num[i] = '0;
        ticks(2);
        chk("rst_fin", Fin, 0);
        chk("rst_m1", m1, 0);
        chk("rst_m2", m2, 0);
        chk("rst_node0", node[0], 0);
        chk("rst_node7", node[7], 0);
        n_Rst = 1'b0;
        tick();

        // Skewed histogram, start held 20 cycles.
        for (int i = 0; i < 10; i++) num[i] = cnt1[i];
        Start_tree = 1'b1;
        tick();                                  // E0
        chk("c1_e0_fin", Fin, 0);
        tick();                                  // E1
        chk("c1_e1_node0", node[0], 15'h20CA);
        ticks(7);                                // E8
        chk("c1_e8_fin", Fin, 0);
        chk("c1_e8_node7", node[7], exp1[7]);
        tick();                                  // E9
        chk("c1_e9_fin", Fin, 1);
        chk("c1_m1", m1, 16);
        chk("c1_m2", m2, 17);
        chk("c1_node7_hex", node[7], 15'h39F1);
        for (int i = 0; i < 8; i++) chk($sformatf("c1_node%0d", i), node[i], exp1[i]);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("c1_hold_fin", Fin, 1);
        end
        chk("c1_hold_node0", node[0], exp1[0]);
        Start_tree = 1'b0;
        tick();

        // One nonzero leaf.
        for (int i = 0; i < 10; i++) num[i] = '0;
        num[0] = 9'd256;
        Start_tree = 1'b1;
        tick();                                  // E0
        tick();                                  // E1
`ifdef HT_ZERO_SKIP_EN
        chk("c2_e1_fin", Fin, 1);
        chk("c2_m1", m1, 0);
        chk("c2_m2", m2, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("c2_node%0d", i), node[i], 0);
        ticks(8);
        chk("c2_late_fin", Fin, 1);
`else
        chk("c2_e1_fin", Fin, 0);
        chk("c2_node0", node[0], nd(1, 2, 10));
        ticks(8);                                // E9
        chk("c2_fin", Fin, 1);
        chk("c2_node4", node[4], nd(9, 10, 14));
        chk("c2_node7", node[7], nd(15, 16, 17));
        chk("c2_m1", m1, 17);
        chk("c2_m2", m2, 0);
`endif
        Start_tree = 1'b0;
        tick();

        // Reset at E4 aborts; a restart reproduces the first tree.
        for (int i = 0; i < 10; i++) num[i] = cnt1[i];
        Start_tree = 1'b1;
        tick();                                  // E0
        ticks(4);                                // E4
        chk("c3_pre_node0", node[0], exp1[0]);
        n_Rst = 1'b1;
        #1;
        chk("c3_rst_fin", Fin, 0);
        chk("c3_rst_m1", m1, 0);
        chk("c3_rst_m2", m2, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("c3_rst_node%0d", i), node[i], 0);
        tick();
        n_Rst = 1'b0;
        tick();                                  // E0 of rebuild
        chk("c3_e0_fin", Fin, 0);
        ticks(9);                                // E9
        chk("c3_fin", Fin, 1);
        chk("c3_m1", m1, 16);
        chk("c3_m2", m2, 17);
        for (int i = 0; i < 8; i++) chk($sformatf("c3_node%0d", i), node[i], exp1[i]);

        // Held start: no second build; then a new request with ties.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c4_hold_fin", Fin, 1);
        end
        Start_tree = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) num[i] = 9'd5;
        Start_tree = 1'b1;
        tick();                                  // E0
        chk("c4_e0_fin", Fin, 0);
        chk("c4_e0_node0", node[0], 0);
        chk("c4_e0_node7", node[7], 0);
        ticks(9);                                // E9
        chk("c4_fin", Fin, 1);
        chk("c4_node0", node[0], nd(0, 1, 10));
        chk("c4_node1", node[1], nd(2, 3, 11));
        chk("c4_node2", node[2], nd(4, 5, 12));
        chk("c4_node3", node[3], nd(6, 7, 13));
        chk("c4_node7", node[7], nd(14, 15, 17));
        chk("c4_m1", m1, 16);
        chk("c4_m2", m2, 17);
        Start_tree = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
